shift_merge_decode: RTL and testbench

- Decodes the shift/merge class instructions EXTR, DEP and DSR into control values for the downstream shift/merge unit.
- Control values produced: shift amount (sa), left mask position (pl) and right mask position (pr).
- Sits in the execute-stage decode path, between the instruction register and the shift/merge datapath.
- Outputs are registered: one cycle of latency.

---
 rtl/vcpu32_pkg.sv | 23 ++
 rtl/shift_merge_decode.sv | 59 +++++
 tb/tb_shift_merge_decode.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vcpu32_pkg.sv
// vcpu32_pkg: opcode and instruction-field constants shared by the vcpu32 decode blocks.
// Instruction bits are numbered [0:31] with bit 0 as the MSB.
package vcpu32_pkg;

    localparam logic [0:5] OP_EXTR = 6'o12;
    localparam logic [0:5] OP_DEP  = 6'o13;
    localparam logic [0:5] OP_DSR  = 6'o14;

    localparam int OP_MSB  = 0;
    localparam int OP_LSB  = 5;
    localparam int A_BIT   = 11;
    localparam int LEN_MSB = 22;
    localparam int LEN_LSB = 26;
    localparam int POS_MSB = 27;
    localparam int POS_LSB = 31;

    typedef struct packed {
        logic [0:4] sa;
        logic [0:4] pl;
        logic [0:4] pr;
    } sm_ctrl_t;

endpackage

// File: rtl/shift_merge_decode.sv
// shift_merge_decode: decodes EXTR/DEP/DSR into registered shift amount and merge mask bounds.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears all outputs
//   instr  - instruction word [0:31], bit 0 = MSB
//   saReg  - shift amount register, used as position when instr[11] is set
//   sa     - right-rotate amount for the shifter
//   pl, pr - left/right bit positions of the merge mask
module shift_merge_decode
    import vcpu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] instr,
    input  logic [0:4]  saReg,
    output logic [0:4]  sa,
    output logic [0:4]  pl,
    output logic [0:4]  pr
);

    logic [0:5] op;
    logic [0:4] len;
    logic [0:4] p;
    logic [5:0] l_full;
    logic       is_extr, is_dep, is_dsr;
    logic       dep_clamp;
    sm_ctrl_t   d, q;

    assign op      = instr[OP_MSB:OP_LSB];
    assign len     = instr[LEN_MSB:LEN_LSB];
    assign p       = instr[A_BIT] ? saReg : instr[POS_MSB:POS_LSB];
    // len = 0 encodes a 32-bit field
    assign l_full  = {len == 5'd0, len};
    assign is_extr = op == OP_EXTR;
    assign is_dep  = op == OP_DEP;
    assign is_dsr  = op == OP_DSR;
    // field would extend past bit 0: clamp the left bound
    assign dep_clamp = l_full > ({1'b0, p} + 6'd1);

    // 5-bit arithmetic wraps modulo 32; len mod 32 equals L mod 32 even for L = 32
    always_comb begin
        d    = '0;
        d.sa = is_extr ? ~p : is_dep ? p + 5'd1 : is_dsr ? p : 5'd0;
        d.pl = is_extr ? 5'd0 - len : (is_dep && !dep_clamp) ? p - len + 5'd1 : 5'd0;
        d.pr = (is_extr || is_dsr) ? 5'd31 : is_dep ? p : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= d;
    end

    assign sa = q.sa;
    assign pl = q.pl;
    assign pr = q.pr;

endmodule

// File: tb/tb_shift_merge_decode.sv
// tb_shift_merge_decode: directed table-driven checks of shift_merge_decode plus reset sequences.
module tb_shift_merge_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] instr = '0;
    logic [0:4]  saReg = '0;
    logic [0:4]  sa, pl, pr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [0:31] instr;
        logic [0:4]  sa_reg;
        logic [0:4]  sa, pl, pr;
    } vec_t;

    vec_t vecs[$];

    shift_merge_decode dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .saReg(saReg),
        .sa(sa), .pl(pl), .pr(pr)
    );

    always #5 clk = ~clk;

    // unused bits are filled with junk to show they are ignored
    function automatic logic [0:31] mk(input logic [0:5] op, input logic a,
                                       input logic [0:4] len, input logic [0:4] pos);
        logic [0:31] w;
        w = 32'h05A5_5A5A;
        w[0:5]   = op;
        w[11]    = a;
        w[22:26] = len;
        w[27:31] = pos;
        return w;
    endfunction

    task automatic chk(input string name, input logic [0:4] esa, input logic [0:4] epl,
                       input logic [0:4] epr);
        checks++;
        if (sa !== esa || pl !== epl || pr !== epr) begin
            errors++;
            $display("FAIL %s: got sa=%0d pl=%0d pr=%0d expected sa=%0d pl=%0d pr=%0d",
                     name, sa, pl, pr, esa, epl, epr);
        end
    endtask

    task automatic add(input string n, input logic [0:31] i, input logic [0:4] s,
                       input logic [0:4] esa, input logic [0:4] epl, input logic [0:4] epr);
        vec_t v;
        v.name = n; v.instr = i; v.sa_reg = s; v.sa = esa; v.pl = epl; v.pr = epr;
        vecs.push_back(v);
    endtask

    initial begin
        add("extr_a0",       mk(6'o12, 1'b0, 5'd10, 5'd19), 5'd0,  5'd12, 5'd22, 5'd31);
        add("extr_a1",       mk(6'o12, 1'b1, 5'd10, 5'd19), 5'd10, 5'd21, 5'd22, 5'd31);
        add("dep_a0",        mk(6'o13, 1'b0, 5'd10, 5'd19), 5'd0,  5'd20, 5'd10, 5'd19);
        add("dep_pos31",     mk(6'o13, 1'b0, 5'd10, 5'd31), 5'd0,  5'd0,  5'd22, 5'd31);
        add("dep_clamp",     mk(6'o13, 1'b0, 5'd8,  5'd3),  5'd0,  5'd4,  5'd0,  5'd3);
        add("dsr_a0",        mk(6'o14, 1'b0, 5'd9,  5'd7),  5'd0,  5'd7,  5'd0,  5'd31);
        add("dsr_a1",        mk(6'o14, 1'b1, 5'd9,  5'd7),  5'd12, 5'd12, 5'd0,  5'd31);
        add("extr_len32",    mk(6'o12, 1'b0, 5'd0,  5'd31), 5'd0,  5'd0,  5'd0,  5'd31);
        add("op_00",         mk(6'o00, 1'b1, 5'd10, 5'd19), 5'd7,  5'd0,  5'd0,  5'd0);
        add("dep_sareg_ign", mk(6'o13, 1'b0, 5'd4,  5'd5),  5'd25, 5'd6,  5'd2,  5'd5);
        add("dep_len32",     mk(6'o13, 1'b0, 5'd0,  5'd31), 5'd3,  5'd0,  5'd0,  5'd31);
        add("dep_exact_fit", mk(6'o13, 1'b0, 5'd11, 5'd10), 5'd0,  5'd11, 5'd0,  5'd10);
        add("dep_mid",       mk(6'o13, 1'b0, 5'd4,  5'd10), 5'd0,  5'd11, 5'd7,  5'd10);
        add("op_15",         mk(6'o15, 1'b0, 5'd10, 5'd19), 5'd0,  5'd0,  5'd0,  5'd0);
        add("extr_sareg0",   mk(6'o12, 1'b1, 5'd1,  5'd19), 5'd0,  5'd31, 5'd31, 5'd31);
        add("dep_len32_p0",  mk(6'o13, 1'b1, 5'd0,  5'd19), 5'd0,  5'd1,  5'd0,  5'd0);

        // reset held: outputs stay zero across edges
        instr = mk(6'o12, 1'b0, 5'd10, 5'd19);
        #1 chk("reset_initial", 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1 chk("reset_held", 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_no_early", 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1 chk("release_first_cap", 5'd12, 5'd22, 5'd31);

        // back-to-back vectors, one per cycle; outputs hold until the next edge
        for (int i = 0; i < vecs.size(); i++) begin
            logic [0:4] psa, ppl, ppr;
            psa = sa; ppl = pl; ppr = pr;
            @(negedge clk);
            instr = vecs[i].instr;
            saReg = vecs[i].sa_reg;
            #1 chk({vecs[i].name, "_hold"}, psa, ppl, ppr);
            @(posedge clk);
            #1 chk(vecs[i].name, vecs[i].sa, vecs[i].pl, vecs[i].pr);
        end

        // mid-stream reset discards the pending decode
        @(negedge clk);
        instr = mk(6'o13, 1'b0, 5'd10, 5'd19);
        saReg = 5'd0;
        @(posedge clk);
        #1 chk("pre_reset", 5'd20, 5'd10, 5'd19);
        @(negedge clk);
        instr = mk(6'o14, 1'b0, 5'd0, 5'd7);
        #2 rst_n = 1'b0;
        #1 chk("async_clear", 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1 chk("reset_mid_held", 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instr = mk(6'o12, 1'b1, 5'd0, 5'd0);
        saReg = 5'd31;
        #1 chk("post_reset_no_stale", 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1 chk("post_reset_first", 5'd0, 5'd0, 5'd31);
        @(negedge clk);
        instr = mk(6'o14, 1'b1, 5'd0, 5'd0);
        saReg = 5'd3;
        @(posedge clk);
        #1 chk("post_reset_second", 5'd3, 5'd0, 5'd31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
